nic_fifo: RTL

Parametrised network interface controller between one processing element and its local mesh router port. Replaces single-entry channel buffers with independent input and output FIFOs of configurable depth, tracked by occupancy counters. All-zero packets are therefore legal data. Adds occupancy and sticky-overflow status visible to the CPU, and a back-to-back streaming path toward the router, gated by router polarity.

---
 rtl/nic_fifo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/nic_fifo.sv
// NIC between a processing element and its mesh router port: independent input and
// output packet FIFOs with occupancy counters, CPU register access and a streaming send path.
module nic_fifo #(
  parameter int PACKET_WIDTH = 64,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              addr,
  input  logic [PACKET_WIDTH-1:0] d_in,
  output logic [PACKET_WIDTH-1:0] d_out,
  input  logic                    nicEn,
  input  logic                    nicEnWR,
  input  logic                    net_si,
  output logic                    net_ri,
  input  logic [PACKET_WIDTH-1:0] net_di,
  output logic                    net_so,
  input  logic                    net_ro,
  output logic [PACKET_WIDTH-1:0] net_do,
  input  logic                    net_polarity
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PACKET_WIDTH-1:0] in_mem  [DEPTH];
  logic [PACKET_WIDTH-1:0] out_mem [DEPTH];

  logic [PW-1:0]           in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [PW-1:0]           out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [CW-1:0]           in_count_q, in_count_d, out_count_q, out_count_d;
  logic                    ovf_q, ovf_d;
  logic [PACKET_WIDTH-1:0] d_out_q, d_out_d, net_do_q, net_do_d;
  logic                    net_so_q, net_so_d;

  logic cpu_rd, cpu_wr_out, in_full, out_full;
  logic in_push, in_pop, send, out_push, ovf_set, ovf_clr;

  always_comb begin
    cpu_rd     = nicEn && !nicEnWR;
    cpu_wr_out = nicEn && nicEnWR && (addr == 2'b10);
    in_full    = (in_count_q == FULL_CNT);
    out_full   = (out_count_q == FULL_CNT);
    // A full input FIFO refuses the router even if the CPU drains it this cycle.
    in_push    = net_si && !in_full;
    in_pop     = cpu_rd && (addr == 2'b00) && (in_count_q != '0);
    send       = (out_count_q != '0) && net_ro && net_polarity;
    out_push   = cpu_wr_out && (!out_full || send);
    ovf_set    = cpu_wr_out && out_full && !send;
    ovf_clr    = cpu_rd && (addr == 2'b11);
  end

  assign net_ri = !in_full;

  always_comb begin
    in_wptr_d   = in_wptr_q;
    in_rptr_d   = in_rptr_q;
    in_count_d  = in_count_q;
    out_wptr_d  = out_wptr_q;
    out_rptr_d  = out_rptr_q;
    out_count_d = out_count_q;
    ovf_d       = ovf_q;
    d_out_d     = d_out_q;
    net_do_d    = net_do_q;
    net_so_d    = send;

    if (in_push) in_wptr_d = in_wptr_q + PW'(1);
    if (in_pop)  in_rptr_d = in_rptr_q + PW'(1);
    case ({in_push, in_pop})
      2'b10:   in_count_d = in_count_q + CW'(1);
      2'b01:   in_count_d = in_count_q - CW'(1);
      default: in_count_d = in_count_q;
    endcase

    if (out_push) out_wptr_d = out_wptr_q + PW'(1);
    if (send) begin
      out_rptr_d = out_rptr_q + PW'(1);
      net_do_d   = out_mem[out_rptr_q];
    end
    case ({out_push, send})
      2'b10:   out_count_d = out_count_q + CW'(1);
      2'b01:   out_count_d = out_count_q - CW'(1);
      default: out_count_d = out_count_q;
    endcase

    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    if (cpu_rd) begin
      case (addr)
        2'b00:   d_out_d = in_pop ? in_mem[in_rptr_q] : '0;
        2'b01:   d_out_d = PACKET_WIDTH'({in_count_q, 1'b0, (in_count_q != '0)});
        2'b10:   d_out_d = '0;
        default: d_out_d = PACKET_WIDTH'({out_count_q, ovf_q, out_full});
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wptr_q   <= '0;
      in_rptr_q   <= '0;
      in_count_q  <= '0;
      out_wptr_q  <= '0;
      out_rptr_q  <= '0;
      out_count_q <= '0;
      ovf_q       <= 1'b0;
      d_out_q     <= '0;
      net_do_q    <= '0;
      net_so_q    <= 1'b0;
    end else begin
      in_wptr_q   <= in_wptr_d;
      in_rptr_q   <= in_rptr_d;
      in_count_q  <= in_count_d;
      out_wptr_q  <= out_wptr_d;
      out_rptr_q  <= out_rptr_d;
      out_count_q <= out_count_d;
      ovf_q       <= ovf_d;
      d_out_q     <= d_out_d;
      net_do_q    <= net_do_d;
      net_so_q    <= net_so_d;
    end
  end

  // Packet storage is deliberately left out of reset; only pointers and counts define contents.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wptr_q]   <= net_di;
    if (out_push) out_mem[out_wptr_q] <= d_in;
  end

  assign d_out  = d_out_q;
  assign net_do = net_do_q;
  assign net_so = net_so_q;

endmodule
